uart_frame_ctrl: RTL
====================

Name: uart_frame_ctrl

Overview:
- Packet controller behind the UART receiver. Consumes received bytes (data + done tick) and assembles framed packets: SYNC, LEN, payload, CHK.
- Buffers the payload and verifies the checksum. Releases only verified payloads to the downstream anomaly-detector core over a valid/ready byte stream.
- Guards against stalled links with an inter-byte timeout measured in oversampling ticks.

Parameters:
- MAX_LEN, 16, maximum payload bytes; buffer depth.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_TICKS, 2048, s_tick count without a new byte that aborts a frame in progress.
- LEN_W, 5, width of length/index counters; must hold MAX_LEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rx_byte  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte
- s_tick  in  1  oversampling tick (16 per bit)
- m_data  out  8  payload byte to downstream
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts
- m_last  out  1  marks final payload byte
- pkt_ok  out  1  pulse: frame verified
- err_chk  out  1  pulse: checksum mismatch
- err_len  out  1  pulse: LEN=0 or LEN>MAX_LEN
- err_timeout  out  1  pulse: inter-byte timeout
- drop  out  1  pulse: byte arrived during DRAIN and was discarded
- busy  out  1  state != HUNT

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous, active-high.
  - Reset drives state=HUNT and zeroes all counters.
  - All outputs are 0 after reset: m_valid, m_last, m_data, every pulse, busy.
  - Reset mid-frame or mid-drain discards the packet; no pulse is emitted.
- HUNT:
  - rx_valid with rx_byte==SYNC_BYTE -> LEN.
  - Any other byte is ignored; no error is raised.
- LEN, on rx_valid:
  - Latch len = rx_byte and set chk_acc = rx_byte.
  - If rx_byte==0 or rx_byte>MAX_LEN -> err_len pulse and return to HUNT.
  - Otherwise set idx=0 -> PAYLOAD.
- PAYLOAD, on rx_valid:
  - buf[idx] = rx_byte; chk_acc ^= rx_byte; idx++.
  - When idx reaches len-1 -> CHK.
- CHK, on rx_valid:
  - If rx_byte==chk_acc -> pkt_ok pulse, idx=0 -> DRAIN.
  - Otherwise -> err_chk pulse -> HUNT.
- DRAIN:
  - m_valid=1 from the cycle after the CHK byte (1-cycle latency); m_data=buf[idx].
  - m_last=1 when idx==len-1.
  - On m_valid&&m_ready: idx++. The handshake on the last byte -> HUNT, and m_valid drops the next cycle.
  - m_data/m_last are held stable while m_valid&&!m_ready.
  - rx_valid during DRAIN is discarded with a drop pulse, including a SYNC byte.
- Timeout:
  - Counter is active only in LEN/PAYLOAD/CHK.
  - Cleared on every rx_valid and on entry to HUNT; increments on s_tick.
  - When it reaches TIMEOUT_TICKS-1 with s_tick -> err_timeout pulse -> HUNT.
  - If rx_valid and the final s_tick coincide, rx_valid wins and the counter clears.
  - No timeout applies in DRAIN; backpressure is unbounded.
- All pulses are registered, exactly one cycle wide, and mutually exclusive per frame.
- Checksum is 8-bit XOR over LEN and all payload bytes; SYNC is excluded.

Decomposition:
- Package uart_frame_pkg holds:
  - the state encoding (HUNT, LEN, PAYLOAD, CHK, DRAIN)
  - SYNC_BYTE default
  - the MAX_LEN and TIMEOUT_TICKS defaults
- Sub-module uart_frame_buf: MAX_LEN x 8 register array with one write port (wr_en, wr_idx, wr_data) and an asynchronous read (rd_idx -> rd_data).
- The FSM, checksum and counters stay in uart_frame_ctrl.

Test Plan:
- Good frame: bytes A5 03 01 02 03 03, m_ready=1 -> pkt_ok once; m_data 01,02,03 on consecutive cycles; m_last with 03; busy returns to 0.
- Bad checksum: A5 02 10 20 31 (correct CHK is 32) -> err_chk once, m_valid never asserts, next good frame passes.
- Length limits: A5 00 -> err_len. A5 11 with MAX_LEN=16 -> err_len. A5 10 + 16 bytes + correct CHK -> 16 outputs, m_last on the 16th.
- Timeout: A5 02 05, then 2048 s_ticks with no byte -> err_timeout, state HUNT. The same sequence with a byte on the 2048th tick -> no timeout.
- Backpressure + drop: good 3-byte frame with m_ready toggling 0/1 -> data held stable while stalled, order preserved. A byte injected mid-drain -> drop pulse, output unaffected.
- Noise and reset: leading 00 FF 5A before A5 are ignored. rst asserted mid-PAYLOAD -> all outputs 0 and no pulses; a following good frame is accepted.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared state encoding and parameter defaults for the UART packet framer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF     = 8'hA5;
  localparam int         MAX_LEN_DEF       = 16;
  localparam int         TIMEOUT_TICKS_DEF = 2048;
  localparam int         LEN_W_DEF         = 5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 registers, one write port, asynchronous read.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [LEN_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_data_i,
  input  logic [LEN_W-1:0] rd_idx_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [MAX_LEN];

  // Contents need no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (wr_idx_i == LEN_W'(i)) mem_q[i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_idx_i == LEN_W'(i)) rd_data_o = mem_q[i];
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame assembler behind the UART receiver: SYNC, LEN, payload, CHK; releases
// only checksum-verified payloads on a valid/ready byte stream.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN       = MAX_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int         LEN_W         = LEN_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       s_tick,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       drop,
  output logic       busy
);

  // state    | meaning
  // HUNT     | waiting for SYNC, everything else ignored
  // LEN      | next byte is the payload length
  // PAYLOAD  | storing payload bytes into the buffer
  // CHK      | next byte is the XOR checksum
  // DRAIN    | streaming the verified payload downstream

  localparam int               TMO_W     = $clog2(TIMEOUT_TICKS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic pkt_ok_q, pkt_ok_d;
  logic err_chk_q, err_chk_d;
  logic err_len_q, err_len_d;
  logic err_tmo_q, err_tmo_d;
  logic drop_q, drop_d;

  logic             wr_en;
  logic [7:0]       rd_data;
  logic [LEN_W-1:0] len_last;
  logic             in_frame;

  assign len_last = len_q - LEN_W'(1);
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (rx_byte),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    tmo_d     = tmo_q;
    pkt_ok_d  = 1'b0;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    drop_d    = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        tmo_d = '0;
        if (rx_valid && (rx_byte == SYNC_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid) begin
          len_d = rx_byte[LEN_W-1:0];
          chk_d = rx_byte;
          if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ rx_byte;
          idx_d = idx_q + LEN_W'(1);
          if (idx_q == len_last) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte == chk_q) begin
            pkt_ok_d = 1'b1;
            idx_d    = '0;
            state_d  = ST_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        if (rx_valid) drop_d = 1'b1;
        if (m_ready) begin
          if (idx_q == len_last) begin
            idx_d   = '0;
            state_d = ST_HUNT;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // A byte arriving on the final tick restarts the inter-byte window.
    if (in_frame) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (s_tick) begin
        if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          tmo_d     = '0;
          state_d   = ST_HUNT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      pkt_ok_q  <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      pkt_ok_q  <= pkt_ok_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      drop_q    <= drop_d;
    end
  end

  // m_data is gated so stale buffer contents never leak when idle.
  assign m_valid     = (state_q == ST_DRAIN);
  assign m_data      = m_valid ? rd_data : 8'h00;
  assign m_last      = m_valid && (idx_q == len_last);
  assign busy        = (state_q != ST_HUNT);
  assign pkt_ok      = pkt_ok_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;
  assign drop        = drop_q;

endmodule
